// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, scheduler state encoding and mix saturation helper
package synth_pkg;
  localparam int NUM_KEYS = 12;
  localparam int NOTE_W = 4;
  localparam int AGE_W = 8;
  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT_WR, WRITE} sched_state_t;
  function automatic logic signed [31:0] sat(input logic signed [31:0] a, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return a > hi ? hi : a < lo ? lo : a;
  endfunction
endpackage

// File: rtl/voice_alloc.sv
// voice_alloc: key edges, pending keys and per-voice note/gate/active/age; steals with VOICE_SCHED_STEAL_EN
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_KEYS-1:0]          keys,
  input  logic [NUM_VOICES-1:0]        release_done,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_retrig
);
  logic [NUM_KEYS-1:0] keys_q, pending, press, rel, cand, key_oh;
  logic [NOTE_W-1:0] note [NUM_VOICES];
  logic [AGE_W-1:0] age [NUM_VOICES];
  logic [NOTE_W-1:0] key;
  logic key_ok;
  logic [NUM_VOICES-1:0] match, hit_oh, free_oh, steal_oh, alloc_oh;
  logic grant;
  assign press = keys & ~keys_q;
  assign rel = ~keys & keys_q;
  assign cand = pending & ~rel;
  assign key_oh = cand & (~cand + 1'b1);
  assign key_ok = |cand;
  always_comb begin
    key = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (cand[k]) key = NOTE_W'(k);
    for (int v = 0; v < NUM_VOICES; v++) begin
      match[v] = voice_active[v] && note[v] == key;
      voice_note[v*NOTE_W +: NOTE_W] = note[v];
    end
  end
  assign hit_oh = match & (~match + 1'b1);
  assign free_oh = ~voice_active & (voice_active + 1'b1);
`ifdef VOICE_SCHED_STEAL_EN
  // Oldest voice wins; at equal age a released voice beats a held one, then lowest index
  always_comb begin
    logic [AGE_W-1:0] best_age;
    logic best_gate;
    steal_oh = NUM_VOICES'(1);
    best_age = age[0];
    best_gate = voice_gate[0];
    for (int v = 1; v < NUM_VOICES; v++)
      if (age[v] > best_age || (age[v] == best_age && !voice_gate[v] && best_gate)) begin
        steal_oh = NUM_VOICES'(1) << v;
        best_age = age[v];
        best_gate = voice_gate[v];
      end
  end
`else
  assign steal_oh = '0;
`endif
  assign alloc_oh = !key_ok ? '0 : |hit_oh ? hit_oh : |free_oh ? free_oh : steal_oh;
  assign grant = |alloc_oh;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      keys_q <= '0;
      pending <= '0;
      voice_gate <= '0;
      voice_active <= '0;
      voice_retrig <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note[v] <= '0;
        age[v] <= '0;
      end
    end else begin
      keys_q <= keys;
      pending <= (pending | press) & ~rel & ~(grant ? key_oh : '0);
      voice_retrig <= alloc_oh;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (alloc_oh[v]) begin
          note[v] <= key;
          voice_gate[v] <= 1'b1;
          voice_active[v] <= 1'b1;
          age[v] <= '0;
        end else begin
          if (rel[note[v]]) voice_gate[v] <= 1'b0;
          if (!voice_gate[v] && release_done[v]) voice_active[v] <= 1'b0;
          if (grant && voice_active[v] && age[v] != '1) age[v] <= age[v] + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: per-tick voice sequencing over the shared datapath, mix accumulate and codec write
// Optional voice stealing is enabled by defining VOICE_SCHED_STEAL_EN.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W = 24
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_KEYS-1:0]          keys,
  input  logic                         sample_tick,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_retrig,
  input  logic [NUM_VOICES-1:0]        release_done,
  output logic                         ds_req,
  output logic [2:0]                   ds_voice,
  input  logic                         ds_ack,
  input  logic [SAMPLE_W-1:0]          ds_sample,
  input  logic                         write_ready,
  output logic                         write,
  output logic [SAMPLE_W-1:0]          mix_out,
  output logic                         overrun
);
  localparam int ACC_W = SAMPLE_W + 3;
  sched_state_t state, next_state;
  logic [3:0] v;
  logic signed [ACC_W-1:0] acc;
  logic [7:0] act_pad;
  logic at_end, cur_active;
  voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .clock(clock),
    .resetn(resetn),
    .keys(keys),
    .release_done(release_done),
    .voice_note(voice_note),
    .voice_gate(voice_gate),
    .voice_active(voice_active),
    .voice_retrig(voice_retrig)
  );
  assign act_pad = 8'(voice_active);
  assign at_end = v == 4'(NUM_VOICES);
  assign cur_active = act_pad[v[2:0]];
  assign ds_req = state == REQ;
  assign write = state == WRITE;
  assign ds_voice = v[2:0];
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = sample_tick ? SCAN : IDLE;
      SCAN:    next_state = at_end ? WAIT_WR : cur_active ? REQ : SCAN;
      REQ:     next_state = ds_ack ? SCAN : REQ;
      WAIT_WR: next_state = write_ready ? WRITE : WAIT_WR;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v <= '0;
      acc <= '0;
      mix_out <= '0;
      overrun <= 1'b0;
    end else begin
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && sample_tick) begin
        acc <= '0;
        v <= '0;
      end
      if (state == SCAN && !at_end && !cur_active) v <= v + 1'b1;
      if (state == REQ && ds_ack) begin
        acc <= acc + {{3{ds_sample[SAMPLE_W-1]}}, ds_sample};
        v <= v + 1'b1;
      end
      // Registered on the way into WRITE so the strobe and the value coincide
      if (state == WAIT_WR && write_ready) mix_out <= SAMPLE_W'(sat(32'(acc), SAMPLE_W));
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed steps with a mix scoreboard and a responding datapath model
module tb_voice_scheduler;
  logic clock = 0;
  logic resetn = 0;
  logic [11:0] keys = 0;
  logic sample_tick = 0;
  logic [15:0] voice_note;
  logic [3:0] voice_gate, voice_active, voice_retrig;
  logic [3:0] release_done = 0;
  logic ds_req;
  logic [2:0] ds_voice;
  logic ds_ack = 0;
  logic [23:0] ds_sample = 0;
  logic write_ready = 1;
  logic write;
  logic [23:0] mix_out;
  logic overrun;
  logic ack_en = 1;
  logic [23:0] tbl [8];
  logic [23:0] exp_q [$];
  int req_cnt [8];
  int base [8];
  int req_tot = 0, base_tot = 0, write_cnt = 0, w0 = 0;
  int checks = 0, passed = 0;
  always #5 clock = ~clock;
  voice_scheduler dut (
    .clock(clock), .resetn(resetn), .keys(keys), .sample_tick(sample_tick),
    .voice_note(voice_note), .voice_gate(voice_gate), .voice_active(voice_active),
    .voice_retrig(voice_retrig), .release_done(release_done), .ds_req(ds_req),
    .ds_voice(ds_voice), .ds_ack(ds_ack), .ds_sample(ds_sample),
    .write_ready(write_ready), .write(write), .mix_out(mix_out), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clock) sample_tick = 1;
    @(negedge clock) sample_tick = 0;
  endtask
  task automatic wait_writes(input int target);
    for (int i = 0; i < 500 && write_cnt < target; i++) @(negedge clock);
    chk("write_seen", 32'(write_cnt >= target), 1);
  endtask
  always @(negedge clock) begin
    if (ds_req && ack_en && !ds_ack) begin
      ds_ack = 1;
      ds_sample = tbl[ds_voice];
      req_cnt[ds_voice]++;
      req_tot++;
    end else ds_ack = 0;
  end
  always @(negedge clock) begin
    if (write) begin
      write_cnt++;
      chk("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("mix_out", 32'(mix_out), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i] = 0;
      req_cnt[i] = 0;
    end
    repeat (3) @(negedge clock);
    chk("rst_gate", 32'(voice_gate), 0);
    chk("rst_active", 32'(voice_active), 0);
    chk("rst_note", 32'(voice_note), 0);
    chk("rst_retrig", 32'(voice_retrig), 0);
    chk("rst_ds_req", 32'(ds_req), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_mix", 32'(mix_out), 0);
    chk("rst_overrun", 32'(overrun), 0);
    resetn = 1;
    keys = 12'h800;
    repeat (2) @(negedge clock);
    chk("t1_retrig", 32'(voice_retrig), 4'b0001);
    chk("t1_note", 32'(voice_note[3:0]), 11);
    chk("t1_gate", 32'(voice_gate), 4'b0001);
    @(negedge clock);
    chk("t1_retrig_end", 32'(voice_retrig), 0);
    base = req_cnt;
    base_tot = req_tot;
    tbl[0] = 24'd1000;
    exp_q.push_back(24'd1000);
    tick();
    wait_writes(1);
    chk("t1_req_v0", 32'(req_cnt[0] - base[0]), 1);
    chk("t1_req_total", 32'(req_tot - base_tot), 1);
    keys = 0;
    @(negedge clock) release_done = 4'b1111;
    repeat (2) @(negedge clock);
    release_done = 0;
    chk("z_active", 32'(voice_active), 0);
    base_tot = req_tot;
    exp_q.push_back(0);
    tick();
    wait_writes(2);
    chk("z_no_req", 32'(req_tot - base_tot), 0);
    keys = 12'hA80;
    repeat (4) @(negedge clock);
    chk("t2_notes", 32'(voice_note), 16'h0B97);
    chk("t2_active", 32'(voice_active), 4'b0111);
    tbl[0] = 24'd100;
    tbl[1] = 24'd200;
    tbl[2] = -24'sd50;
    base_tot = req_tot;
    exp_q.push_back(24'd250);
    tick();
    wait_writes(3);
    chk("t2_req_total", 32'(req_tot - base_tot), 3);
    keys = 12'hA81;
    repeat (3) @(negedge clock);
    chk("t3_active", 32'(voice_active), 4'b1111);
    for (int i = 0; i < 4; i++) tbl[i] = 24'h7FFFFF;
    exp_q.push_back(24'h7FFFFF);
    tick();
    wait_writes(4);
    for (int i = 0; i < 4; i++) tbl[i] = 24'h800000;
    exp_q.push_back(24'h800000);
    tick();
    wait_writes(5);
    keys = 12'h881;
    @(negedge clock);
    chk("t4_gate", 32'(voice_gate), 4'b1101);
    chk("t4_active_held", 32'(voice_active), 4'b1111);
    release_done = 4'b0010;
    @(negedge clock) release_done = 0;
    chk("t4_freed", 32'(voice_active), 4'b1101);
    base = req_cnt;
    for (int i = 0; i < 4; i++) tbl[i] = 24'(10 * (i + 1));
    exp_q.push_back(24'd80);
    tick();
    wait_writes(6);
    chk("t4_skip_v1", 32'(req_cnt[1] - base[1]), 0);
    keys = 12'hA81;
    repeat (2) @(negedge clock);
    chk("t5_realloc", 32'(voice_retrig), 4'b0010);
    @(negedge clock) keys = 12'hAA1;
    repeat (2) @(negedge clock);
`ifdef VOICE_SCHED_STEAL_EN
    chk("t5_steal_retrig", 32'(voice_retrig), 4'b0001);
    chk("t5_steal_note", 32'(voice_note[3:0]), 5);
`else
    chk("t5_no_steal", 32'(voice_retrig), 0);
    repeat (5) @(negedge clock);
    chk("t5_held_notes", 32'(voice_note), 16'h0B97);
    keys = 12'h2A1;
    @(negedge clock) release_done = 4'b0100;
    @(negedge clock) release_done = 0;
    @(negedge clock);
    chk("t5_alloc_retrig", 32'(voice_retrig), 4'b0100);
    chk("t5_alloc_note", 32'(voice_note[11:8]), 5);
`endif
    repeat (2) @(negedge clock);
    chk("t6_active", 32'(voice_active), 4'b1111);
    for (int i = 0; i < 4; i++) tbl[i] = 24'(i + 1);
    write_ready = 0;
    ack_en = 0;
    exp_q.push_back(24'd10);
    tick();
    repeat (3) @(negedge clock);
    chk("t6_in_req", 32'(ds_req), 1);
    tick();
    chk("t6_overrun", 32'(overrun), 1);
    w0 = write_cnt;
    ack_en = 1;
    repeat (20) @(negedge clock);
    chk("t6_no_write", 32'(write_cnt), 32'(w0));
    chk("t6_req_idle", 32'(ds_req), 0);
    write_ready = 1;
    wait_writes(w0 + 1);
    repeat (10) @(negedge clock);
    chk("t6_one_write", 32'(write_cnt), 32'(w0 + 1));
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Polyphonic voice controller for the synthesizer.
- Maps the 12 held-key levels from the keyboard tracker onto NUM_VOICES voice slots, each with a note and a gate.
- Each sample tick, it sequences the shared wave/ADSR datapath once per active voice and accumulates the returned samples.
- It writes the saturated mix to the audio codec through the write_ready/write handshake.
- Sits between keyboard_tracker/rate divider and the datapath/audio_codec; replaces the single-note KEYBOARD_LISTEN…UPDATE_PHASE loop.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..8).
- NUM_KEYS, 12, width of the key vector.
- SAMPLE_W, 24, signed sample width from the datapath and to the codec.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-low reset.
- keys  in  NUM_KEYS  held-key levels; bit 11 = a … bit 0 = j.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- voice_note  out  NUM_VOICES*4  per-voice key index 0..11.
- voice_gate  out  NUM_VOICES  key still held.
- voice_active  out  NUM_VOICES  voice sounding (attack through release).
- voice_retrig  out  NUM_VOICES  one-cycle pulse on (re)allocation; resets the phase and attack for that voice.
- release_done  in  NUM_VOICES  datapath release finished, per voice.
- ds_req  out  1  datapath sample request.
- ds_voice  out  3  voice being computed.
- ds_ack  in  1  datapath sample valid.
- ds_sample  in  SAMPLE_W  signed sample for ds_voice.
- write_ready  in  1  codec FIFO has space.
- write  out  1  one-cycle codec write strobe.
- mix_out  out  SAMPLE_W  mixed sample; left and right channels are both driven from it.
- overrun  out  1  sticky; a tick arrived while the scheduler was busy.

Behaviour:
- Reset (resetn=0, async): all outputs 0, voice_note = 0, per-voice age = 0, pending = 0, FSM in IDLE.
- Key edges:
  - keys_q is keys registered once.
  - press = keys & ~keys_q.
  - rel = ~keys & keys_q.
  - pending |= press.
  - pending &= ~rel, so a key released before allocation is dropped.
- Allocation: at most one pending key per cycle, lowest index first. Selection order:
  1. A voice already holding that note with active=1 is reused (retrigger).
  2. Otherwise the lowest-index voice with active=0.
  3. Otherwise steal (see Optional Feature).
- On allocation:
  - Set note, gate=1, active=1, and pulse retrig on the next cycle.
  - Clear the pending bit.
  - Increment the age of every other active voice, saturating at 255; set the chosen voice's age to 0.
- Release:
  - For every voice whose note is in rel, gate←0 the same cycle; all matches are processed, no limit.
  - active←0 when gate=0 and release_done[v]=1.
  - If allocation and freeing hit voice v in the same cycle, allocation wins and active stays 1.
  - Free-voice checks use registered state only.
- Scheduler FSM:
  - IDLE: on sample_tick, clear acc, v←0 → SCAN.
  - SCAN: if v==NUM_VOICES → WAIT_WR. Else if active[v], go to REQ; otherwise v++ (one cycle per skipped voice).
  - REQ: ds_req=1, ds_voice=v, held until ds_ack. On ack, acc += sign-extended ds_sample, v++ → SCAN. ds_req drops the cycle after ack.
  - WAIT_WR: when write_ready=1 → WRITE.
  - WRITE: write=1 for exactly one cycle; mix_out registered = acc saturated to the SAMPLE_W signed range, held until the next WRITE → IDLE.
- Accumulator width is SAMPLE_W+3.
  - Saturation bounds are +2^(SAMPLE_W-1)-1 and -2^(SAMPLE_W-1).
- Zero active voices: still write mix_out=0 on each tick, so codec timing stays fixed.
- sample_tick outside IDLE: tick dropped, overrun←1; cleared only by reset.
- A voice freed mid-scan is still sampled if its bit was already passed; a voice allocated mid-scan is picked up if v has not passed it.
- Reset mid-operation: the FSM returns to IDLE immediately and ds_req/write drop asynchronously.

Optional Feature:
- Macro VOICE_SCHED_STEAL_EN.
- Defined: with all voices active, steal the voice with the largest age (ties → lowest index, prefer gate=0 over gate=1 at equal age); it is retriggered with the new note.
- Undefined: with all voices active, the pending key stays pending until a voice frees, or until the key is released (then dropped). No stealing logic is synthesized.

Decomposition:
- Package synth_pkg: NUM_KEYS, NOTE_W=4, AGE_W=8, the scheduler state encoding (IDLE, SCAN, REQ, WAIT_WR, WRITE) and the saturation helper function.
- Sub-module voice_alloc: key edge detection, pending, note/gate/active/age registers and the steal logic.
- The top level holds the scheduler FSM, accumulator and codec handshake.

Test Plan:
- Press key 11 alone, then tick with ds_sample=1000 → voice0 note=11, gate=1, retrig pulse; one ds_req with ds_voice=0; write once with mix_out=1000.
- Press keys 11, 9, 7 in the same cycle → allocated over 3 consecutive cycles to voices 0, 1, 2; samples 100, 200, -50 → mix_out=250.
- Four voices each returning 0x7FFFFF → mix_out=0x7FFFFF (saturated); four returning 0x800000 → 0x800000.
- Release key 9 → voice1 gate=0 the next cycle, active stays 1; release_done[1]=1 → active=0, and voice1 is skipped on the next scan.
- Hold 4 keys, press a fifth:
  - with VOICE_SCHED_STEAL_EN, the oldest voice (voice0) gets the new note and retrig;
  - without it, no change until a voice frees, then allocation.
- Tick during REQ with ds_ack held low, write_ready=0 → overrun=1; exactly one write after write_ready rises.
